// File: rtl/pipe_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_run_ctrl
//
// Run-control block for the pipelined CPU. It derives the stage clock-enable
// pulse from a programmable divider and adds single-step and burst gating. It
// owns the RUN / SLEEP / HALT state, latches and masks the interrupt lines,
// reports the highest-priority enabled pending interrupt, and counts enabled
// cycles while the core is not halted.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset (overrides everything)
//   clock_divider  divider terminal count; clk_en period = clock_divider+1
//   mode           0 free-run, 1 single-step, 2 burst, 3 reserved (free-run)
//   step_req       pulse; grants 1 tick (step) or burst_len ticks (burst)
//   burst_len      ticks granted per step_req in burst mode
//   wb_halt        halt instruction retired in writeback
//   wb_sleep       sleep instruction retired in writeback
//   interrupts     raw level interrupt lines, sampled every clk
//   irq_mask       per-line enable, 1 = enabled
//   irq_ack        pulse; clears pending bit irq_ack_id
//   irq_ack_id     index of the pending bit to clear
//   clk_en         registered stage clock-enable pulse
//   halt           core halted (sticky until rst)
//   sleep          core sleeping
//   halt_or_sleep  halt | sleep
//   irq_pending    latched pending bits
//   irq_valid      any pending bit that is also enabled
//   irq_id         lowest enabled pending index, 0 when none
//   cycle_count    number of enabled cycles spent outside HALT
// -----------------------------------------------------------------------------
module pipe_run_ctrl #(
   parameter int NUM_IRQ  = 16,
   parameter int IRQ_ID_W = 4,
   parameter int DIV_W    = 32,
   parameter int BURST_W  = 8,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIV_W-1:0]    clock_divider,
   input  logic [1:0]          mode,
   input  logic                step_req,
   input  logic [BURST_W-1:0]  burst_len,
   input  logic                wb_halt,
   input  logic                wb_sleep,
   input  logic [NUM_IRQ-1:0]  interrupts,
   input  logic [NUM_IRQ-1:0]  irq_mask,
   input  logic                irq_ack,
   input  logic [IRQ_ID_W-1:0] irq_ack_id,
   output logic                clk_en,
   output logic                halt,
   output logic                sleep,
   output logic                halt_or_sleep,
   output logic [NUM_IRQ-1:0]  irq_pending,
   output logic                irq_valid,
   output logic [IRQ_ID_W-1:0] irq_id,
   output logic [CNT_W-1:0]    cycle_count
);

   // Run modes
   localparam logic [1:0] MODE_FREE  = 2'd0;
   localparam logic [1:0] MODE_STEP  = 2'd1;
   localparam logic [1:0] MODE_BURST = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

   // Increment / decrement constants sized to their counters
   localparam logic [DIV_W-1:0]   DIV_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
   localparam logic [BURST_W-1:0] CREDIT_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
   localparam logic [BURST_W-1:0] CREDIT_NIL = {BURST_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SLEEP = 2'd1,
      ST_HALT  = 2'd2
   } run_state_t;

   run_state_t         state;
   logic [DIV_W-1:0]   div_cnt;
   logic [BURST_W-1:0] credit;
   logic               tick;
   logic               credit_mode;
   logic               gate;
   logic [NUM_IRQ-1:0] ack_vec;
   logic [NUM_IRQ-1:0] irq_enabled;

   // Divider terminal-count detect; >= lets a lowered divider take effect at once
   always_comb begin
      tick = 1'b0;
      if (div_cnt >= clock_divider) begin
         tick = 1'b1;
      end else begin
         tick = 1'b0;
      end
   end

   // Divider counter: restarts from zero on every tick
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= DIV_ZERO;
      end else if (tick) begin
         div_cnt <= DIV_ZERO;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   // Tick gate: free-run passes every tick, step/burst only while credit remains
   always_comb begin
      credit_mode = 1'b0;
      gate        = 1'b1;
      case (mode)
         MODE_FREE: begin
            credit_mode = 1'b0;
            gate        = 1'b1;
         end
         MODE_STEP, MODE_BURST: begin
            credit_mode = 1'b1;
            gate        = (credit != CREDIT_NIL);
         end
         MODE_RSVD: begin
            credit_mode = 1'b0;
            gate        = 1'b1;
         end
         default: begin
            credit_mode = 1'b0;
            gate        = 1'b1;
         end
      endcase
   end

   // Tick credit: a step request reloads (never adds) and beats a same-cycle consume
   always_ff @(posedge clk) begin
      if (rst) begin
         credit <= CREDIT_NIL;
      end else if (mode == MODE_FREE) begin
         credit <= CREDIT_NIL;
      end else if (step_req && (mode == MODE_STEP)) begin
         credit <= CREDIT_ONE;
      end else if (step_req && (mode == MODE_BURST)) begin
         credit <= burst_len;
      end else if (tick && credit_mode && (credit != CREDIT_NIL)) begin
         credit <= credit - CREDIT_ONE;
      end else begin
         credit <= credit;
      end
   end

   // Registered stage enable; forced high out of reset to match power-on behaviour
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_en <= 1'b1;
      end else begin
         clk_en <= tick & gate;
      end
   end

   // Run state machine with registered status outputs, advanced only on enabled cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         halt          <= 1'b0;
         sleep         <= 1'b0;
         halt_or_sleep <= 1'b0;
      end else if (clk_en) begin
         case (state)
            ST_RUN: begin
               if (wb_halt) begin
                  state         <= ST_HALT;
                  halt          <= 1'b1;
                  sleep         <= 1'b0;
                  halt_or_sleep <= 1'b1;
               end else if (wb_sleep) begin
                  state         <= ST_SLEEP;
                  halt          <= 1'b0;
                  sleep         <= 1'b1;
                  halt_or_sleep <= 1'b1;
               end else begin
                  state         <= ST_RUN;
                  halt          <= 1'b0;
                  sleep         <= 1'b0;
                  halt_or_sleep <= 1'b0;
               end
            end
            ST_SLEEP: begin
               if (wb_halt) begin
                  state         <= ST_HALT;
                  halt          <= 1'b1;
                  sleep         <= 1'b0;
                  halt_or_sleep <= 1'b1;
               end else if (irq_valid) begin
                  state         <= ST_RUN;
                  halt          <= 1'b0;
                  sleep         <= 1'b0;
                  halt_or_sleep <= 1'b0;
               end else begin
                  state         <= ST_SLEEP;
                  halt          <= 1'b0;
                  sleep         <= 1'b1;
                  halt_or_sleep <= 1'b1;
               end
            end
            ST_HALT: begin
               state         <= ST_HALT;
               halt          <= 1'b1;
               sleep         <= 1'b0;
               halt_or_sleep <= 1'b1;
            end
            default: begin
               // An illegal encoding parks the core in the safe halted state
               state         <= ST_HALT;
               halt          <= 1'b1;
               sleep         <= 1'b0;
               halt_or_sleep <= 1'b1;
            end
         endcase
      end else begin
         state         <= state;
         halt          <= halt;
         sleep         <= sleep;
         halt_or_sleep <= halt_or_sleep;
      end
   end

   // Enabled-cycle counter; wraps naturally and freezes once halted
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= CNT_ZERO;
      end else if (clk_en && (state != ST_HALT)) begin
         cycle_count <= cycle_count + CNT_ONE;
      end else begin
         cycle_count <= cycle_count;
      end
   end

   // One-hot acknowledge vector; an index with no matching line selects nothing
   always_comb begin
      ack_vec = {NUM_IRQ{1'b0}};
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (irq_ack && (int'(irq_ack_id) == i)) begin
            ack_vec[i] = 1'b1;
         end else begin
            ack_vec[i] = 1'b0;
         end
      end
   end

   // Pending latch runs every clk; a new level on the line beats a same-cycle ack
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_pending <= {NUM_IRQ{1'b0}};
      end else begin
         irq_pending <= (irq_pending & ~ack_vec) | interrupts;
      end
   end

   // Fixed-priority encoder over enabled pending bits, index 0 highest
   always_comb begin
      irq_enabled = irq_pending & irq_mask;
      irq_valid   = |irq_enabled;
      irq_id      = {IRQ_ID_W{1'b0}};
      // Scan downward so the lowest set index is the last one written
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_enabled[i]) begin
            irq_id = i[IRQ_ID_W-1:0];
         end else begin
            irq_id = irq_id;
         end
      end
   end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Parametrised run-control block for the pipelined CPU. It generates the clock-enable pulse from a programmable divider and adds single-step and burst modes. It owns the RUN/SLEEP/HALT state, latches and masks NUM_IRQ interrupt lines, and reports the highest-priority pending interrupt. It sits beside the pipeline top and drives clk_en, halt, sleep and the cycle counter that the stages and ret_val path consume.

Parameters:
NUM_IRQ, 16, number of interrupt lines
IRQ_ID_W, 4, width of interrupt index; must equal clog2(NUM_IRQ)
DIV_W, 32, width of clock_divider and of the internal divider counter
BURST_W, 8, width of burst length
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clock_divider  in  DIV_W  divider terminal count; clk_en period = clock_divider+1 cycles
mode  in  2  0=free-run, 1=single-step, 2=burst, 3=reserved (treated as free-run)
step_req  in  1  pulse; grants 1 tick (step) or burst_len ticks (burst)
burst_len  in  BURST_W  ticks granted per step_req in burst mode
wb_halt  in  1  halt retired in writeback
wb_sleep  in  1  sleep retired in writeback
interrupts  in  NUM_IRQ  raw interrupt lines, level, sampled every clk
irq_mask  in  NUM_IRQ  1=enabled
irq_ack  in  1  pulse; clears pending bit irq_ack_id
irq_ack_id  in  IRQ_ID_W  index to clear
clk_en  out  1  stage clock-enable pulse
halt  out  1  core halted (sticky)
sleep  out  1  core sleeping
halt_or_sleep  out  1  halt | sleep
irq_pending  out  NUM_IRQ  latched pending bits
irq_valid  out  1  |(irq_pending & irq_mask)
irq_id  out  IRQ_ID_W  lowest index set in irq_pending & irq_mask; 0 when none
cycle_count  out  CNT_W  enabled cycles while not halted

Behaviour:
- Reset (synchronous, takes priority over everything): div counter=0, credit=0, state=RUN, clk_en=1, halt=0, sleep=0, irq_pending=0, cycle_count=0. clk_en=1 in the first post-reset cycle matches existing power-on behaviour.
- Divider tick: each cycle, if cnt >= clock_divider then tick=1 and cnt<=0; else cnt<=cnt+1 and tick=0. The comparison is >=, so lowering the divider mid-count takes effect on the next cycle. clock_divider=0 gives a tick every cycle.
- clk_en is registered: clk_en <= tick & gate, where gate depends on mode:
  - Mode 0 or 3: gate=1.
  - Modes 1 and 2: gate = (credit != 0), and credit decrements on every gated tick.
  - A step_req in mode 1 sets credit to 1. A step_req in mode 2 sets credit to burst_len; burst_len=0 grants nothing.
  - A step_req arriving while credit != 0 reloads credit; it does not add.
  - If step_req and a consuming tick fall in the same cycle, the reload wins.
  - Changing mode to 0 clears credit.
- State machine (updated only in cycles where clk_en=1), states RUN, SLEEP, HALT:
  - RUN -> HALT on wb_halt. RUN -> SLEEP on wb_sleep. If both are set, HALT wins.
  - SLEEP -> RUN when irq_valid=1. SLEEP -> HALT on wb_halt.
  - HALT is terminal until rst.
  - Outputs: halt=(state==HALT), sleep=(state==SLEEP), halt_or_sleep=halt|sleep.
- Interrupt latching runs every clk, independent of clk_en: irq_pending <= (irq_pending & ~ack_vec) | interrupts.
  - ack_vec is a one-hot vector of irq_ack_id, active only when irq_ack=1.
  - If an ack and a set hit the same bit in the same cycle, the set wins.
  - irq_ack_id >= NUM_IRQ is ignored.
  - Masked bits still latch but do not assert irq_valid and do not wake SLEEP.
- irq_valid and irq_id are combinational from the registered irq_pending and the irq_mask input. Priority is fixed: index 0 is highest.
- cycle_count increments by 1 in every cycle where clk_en=1 and state != HALT. It wraps modulo 2^CNT_W and freezes once HALT is entered.
- Latency:
  - interrupts -> irq_pending: 1 cycle.
  - Pending -> SLEEP exit: on the next clk_en.
  - step_req -> first clk_en: at or after the next divider tick, plus 1 register cycle.

Test Plan:
- Tick period: rst, then clock_divider=3, mode=0 -> clk_en high exactly one cycle in every 4. clock_divider=0 -> clk_en held high continuously.
- Single step: mode=1, clock_divider=2, one step_req pulse -> exactly 1 clk_en pulse. No further pulses over 20 cycles. cycle_count advances by 1.
- Burst: mode=2, burst_len=5, step_req -> exactly 5 clk_en pulses. A second step_req issued mid-burst with burst_len=3 -> 3 further pulses from the reload point, not 3 added to the remaining count.
- Sleep and wake:
  - wb_sleep on a clk_en cycle -> sleep=1.
  - interrupts[7]=1 with irq_mask[7]=0 -> sleep stays 1, irq_pending[7]=1.
  - Then set irq_mask[7]=1 -> irq_valid=1, irq_id=7, sleep=0 after the next clk_en.
- Priority and ack collision:
  - Pending bits 3 and 9 -> irq_id=3.
  - irq_ack with id 3 while interrupts[3] is still high -> bit 3 stays set.
  - Drop interrupts[3], then ack -> irq_id=9.
- Halt: wb_halt and wb_sleep together -> halt=1, sleep=0, cycle_count frozen. An interrupt arriving afterwards does not resume. rst -> all outputs return to reset values, clk_en=1.
